// File: rtl/otter_mmio_io.sv
// OTTER MMIO peripheral: debounced switches/buttons, button-edge IRQ, LEDs, 7-seg scanner, MCU reset sequencer.
// Define OTTER_MMIO_SSEG_RAW_EN to add the SSEG_RAW register (0x18) and CTRL bit1 raw-segment mode.
module otter_mmio_io #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
  parameter int          N_SW         = 16,
  parameter int          N_BTN        = 5,
  parameter int          N_LED        = 16,
  parameter int          DB_CYCLES    = 50000,
  parameter int          SCAN_DIV     = 50000,
  parameter int          RESET_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       iobus_addr,
  input  logic [31:0]       iobus_out,
  input  logic              iobus_wr,
  output logic [31:0]       iobus_in,
  input  logic [N_SW-1:0]   switches,
  input  logic [N_BTN-1:0]  buttons,
  input  logic              mcu_reset_req,
  output logic [N_LED-1:0]  leds,
  output logic [7:0]        segs,
  output logic [3:0]        an,
  output logic              irq,
  output logic              mcu_reset
);
  localparam int N_IN = N_SW + N_BTN;
  localparam int DBW  = $clog2(DB_CYCLES);
  localparam int SCW  = $clog2(SCAN_DIV);
  localparam int RCW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [RCW-1:0] RST_LAST  = RCW'(RESET_CYCLES - 1);

  typedef enum logic {HOLD, RUN} rst_state_e;

  logic [N_IN-1:0]  in_s1_q, in_s1_d, in_s2_q, in_s2_d, stable_q;
  logic             req_s1_q, req_s1_d, req_s2_q, req_s2_d;
  logic [N_BTN-1:0] btn_rise;
  logic [N_LED-1:0] led_q, led_d;
  logic [15:0]      sseg_val_q, sseg_val_d;
  logic             disp_en_q, disp_en_d;
  logic [N_BTN-1:0] irq_mask_q, irq_mask_d, edge_q, edge_d;
  logic             irq_q, irq_d;
  logic [SCW-1:0]   presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       segs_q, segs_d;
  logic [3:0]       an_q, an_d;
  rst_state_e       state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic             mcu_reset_q, mcu_reset_d;
  logic             in_win;
  logic [4:0]       off;
  logic [3:0]       nibble;
  logic             unused_bits;

  assign in_win      = (iobus_addr[31:5] == BASE_ADDR[31:5]);
  assign off         = iobus_addr[4:0];
  assign unused_bits = ^iobus_out;

  always_comb begin
    in_s1_d  = {buttons, switches};
    in_s2_d  = in_s1_q;
    req_s1_d = mcu_reset_req;
    req_s2_d = req_s1_q;
  end

  // Per-bit debounce: stable follows sync only after DB_CYCLES consecutive disagreeing cycles.
  genvar gi;
  for (gi = 0; gi < N_IN; gi++) begin : g_db
    logic [DBW-1:0] cnt_q, cnt_d;
    logic           stb_q, stb_d;
    always_comb begin
      cnt_d = '0;
      stb_d = stb_q;
      if (in_s2_q[gi] != stb_q) begin
        if (cnt_q == DB_LAST) stb_d = in_s2_q[gi];
        else                  cnt_d = cnt_q + 1'b1;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        stb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        stb_q <= stb_d;
      end
    end
    assign stable_q[gi] = stb_q;
    if (gi >= N_SW) begin : g_rise
      assign btn_rise[gi-N_SW] = stb_d & ~stb_q;
    end
  end

`ifdef OTTER_MMIO_SSEG_RAW_EN
  logic        raw_mode_q, raw_mode_d;
  logic [31:0] sseg_raw_q, sseg_raw_d;
`endif

  always_comb begin
    led_d      = led_q;
    sseg_val_d = sseg_val_q;
    disp_en_d  = disp_en_q;
    irq_mask_d = irq_mask_q;
    edge_d     = edge_q;
`ifdef OTTER_MMIO_SSEG_RAW_EN
    raw_mode_d = raw_mode_q;
    sseg_raw_d = sseg_raw_q;
`endif
    if (iobus_wr && in_win) begin
      case (off)
        5'h08: edge_d     = edge_q & ~iobus_out[N_BTN-1:0];
        5'h0C: led_d      = iobus_out[N_LED-1:0];
        5'h10: sseg_val_d = iobus_out[15:0];
        5'h14: begin
          disp_en_d  = iobus_out[0];
          irq_mask_d = iobus_out[8 +: N_BTN];
`ifdef OTTER_MMIO_SSEG_RAW_EN
          raw_mode_d = iobus_out[1];
`endif
        end
`ifdef OTTER_MMIO_SSEG_RAW_EN
        5'h18: sseg_raw_d = iobus_out;
`endif
        default: ;
      endcase
    end
    // A new edge in the same cycle as a W1C write must survive.
    edge_d = edge_d | btn_rise;
    irq_d  = |(edge_q & irq_mask_q);
  end

  always_comb begin
    iobus_in = '0;
    if (in_win) begin
      case (off)
        5'h00: iobus_in[N_SW-1:0]  = stable_q[N_SW-1:0];
        5'h04: iobus_in[N_BTN-1:0] = stable_q[N_IN-1:N_SW];
        5'h08: iobus_in[N_BTN-1:0] = edge_q;
        5'h0C: iobus_in[N_LED-1:0] = led_q;
        5'h10: iobus_in[15:0]      = sseg_val_q;
        5'h14: begin
          iobus_in[0]          = disp_en_q;
          iobus_in[8 +: N_BTN] = irq_mask_q;
`ifdef OTTER_MMIO_SSEG_RAW_EN
          iobus_in[1]          = raw_mode_q;
`endif
        end
`ifdef OTTER_MMIO_SSEG_RAW_EN
        5'h18: iobus_in = sseg_raw_q;
`endif
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign nibble = sseg_val_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    presc_d = '0;
    idx_d   = '0;
    an_d    = 4'hF;
    segs_d  = 8'hFF;
    if (disp_en_q) begin
      if (presc_q == SCAN_LAST) begin
        idx_d = idx_q + 2'd1;
      end else begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
      end
      an_d   = ~(4'b0001 << idx_q);
      segs_d = hex7(nibble);
`ifdef OTTER_MMIO_SSEG_RAW_EN
      if (raw_mode_q) segs_d = sseg_raw_q[{idx_q, 3'b000} +: 8];
`endif
    end
  end

  // Reset sequencer: a held request keeps reloading the countdown.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      HOLD: begin
        if (req_s2_q)               rst_cnt_d = RST_LAST;
        else if (rst_cnt_q == '0)   state_d   = RUN;
        else                        rst_cnt_d = rst_cnt_q - 1'b1;
      end
      RUN: begin
        if (req_s2_q) begin
          state_d   = HOLD;
          rst_cnt_d = RST_LAST;
        end
      end
      default: state_d = HOLD;
    endcase
    mcu_reset_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1_q     <= '0;
      in_s2_q     <= '0;
      req_s1_q    <= 1'b0;
      req_s2_q    <= 1'b0;
      led_q       <= '0;
      sseg_val_q  <= '0;
      disp_en_q   <= 1'b0;
      irq_mask_q  <= '0;
      edge_q      <= '0;
      irq_q       <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
      segs_q      <= 8'hFF;
      an_q        <= 4'hF;
      state_q     <= HOLD;
      rst_cnt_q   <= RST_LAST;
      mcu_reset_q <= 1'b1;
    end else begin
      in_s1_q     <= in_s1_d;
      in_s2_q     <= in_s2_d;
      req_s1_q    <= req_s1_d;
      req_s2_q    <= req_s2_d;
      led_q       <= led_d;
      sseg_val_q  <= sseg_val_d;
      disp_en_q   <= disp_en_d;
      irq_mask_q  <= irq_mask_d;
      edge_q      <= edge_d;
      irq_q       <= irq_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      segs_q      <= segs_d;
      an_q        <= an_d;
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      mcu_reset_q <= mcu_reset_d;
    end
  end

`ifdef OTTER_MMIO_SSEG_RAW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_mode_q <= 1'b0;
      sseg_raw_q <= '0;
    end else begin
      raw_mode_q <= raw_mode_d;
      sseg_raw_q <= sseg_raw_d;
    end
  end
`endif

  assign leds      = led_q;
  assign segs      = segs_q;
  assign an        = an_q;
  assign irq       = irq_q;
  assign mcu_reset = mcu_reset_q;
endmodule

// File: tb/tb_otter_mmio_io.sv
// Scoreboard bench for otter_mmio_io: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_otter_mmio_io;
  localparam logic [31:0] BASE = 32'h1100_0000;
  localparam int N_SW = 16, N_BTN = 5, N_LED = 16, DB = 4, SCAN = 8, RC = 16;
  localparam logic [31:0] A_SW = BASE, A_BTN = BASE + 32'h4, A_EDGE = BASE + 32'h8, A_LED = BASE + 32'hC;
  localparam logic [31:0] A_SSEG = BASE + 32'h10, A_CTRL = BASE + 32'h14, A_RAW = BASE + 32'h18;

  logic clk = 1'b0, rst_n;
  logic [31:0] iobus_addr, iobus_out, iobus_in;
  logic iobus_wr, mcu_reset_req, irq, mcu_reset;
  logic [N_SW-1:0] switches;
  logic [N_BTN-1:0] buttons;
  logic [N_LED-1:0] leds;
  logic [7:0] segs;
  logic [3:0] an;

  otter_mmio_io #(.BASE_ADDR(BASE), .N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED),
                  .DB_CYCLES(DB), .SCAN_DIV(SCAN), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .iobus_addr(iobus_addr), .iobus_out(iobus_out), .iobus_wr(iobus_wr),
    .iobus_in(iobus_in), .switches(switches), .buttons(buttons), .mcu_reset_req(mcu_reset_req),
    .leds(leds), .segs(segs), .an(an), .irq(irq), .mcu_reset(mcu_reset));

  always #5 clk = ~clk;

  typedef enum int {K_RD, K_LEDS, K_SEGS, K_AN, K_IRQ, K_MRST} kind_e;
  typedef struct {
    int          at;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mon_act;

  // Reference model state
  logic [15:0] led_m, sseg_m, sw_m, nsw, mv;
  logic [4:0]  mask_m, edge_m, btn_m, nbt;
  logic        rawmode_m;
  logic [31:0] raw_m, rd_tmp;
  logic [7:0]  hex_tab [16];
  int          q0, r0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        case (sb[i].kind)
          K_RD:    mon_act = iobus_in;
          K_LEDS:  mon_act = {16'h0, leds};
          K_SEGS:  mon_act = {24'h0, segs};
          K_AN:    mon_act = {28'h0, an};
          K_IRQ:   mon_act = {31'h0, irq};
          default: mon_act = {31'h0, mcu_reset};
        endcase
        n_cmp++;
        if (mon_act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%h required=%h", sb[i].name, cyc, mon_act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_at(input int at, input kind_e k, input logic [31:0] e, input string nm);
    chk_t c;
    c.at = at; c.kind = k; c.exp = e; c.name = nm;
    sb.push_back(c);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a; iobus_out = d; iobus_wr = 1'b1;
    tick();
    iobus_wr = 1'b0; iobus_addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    iobus_addr = a;
    exp_at(cyc, K_RD, e, nm);
    tick();
    iobus_addr = 32'h0;
  endtask

  task automatic pins_reset(input int at);
    exp_at(at, K_LEDS, 32'h0, "rst_leds");
    exp_at(at, K_AN, 32'hF, "rst_an");
    exp_at(at, K_SEGS, 32'hFF, "rst_segs");
    exp_at(at, K_IRQ, 32'h0, "rst_irq");
    exp_at(at, K_MRST, 32'h1, "rst_mcu_reset");
  endtask

  function automatic logic [31:0] ctrl_word(input logic [4:0] m, input logic [7:0] lo);
    return {19'h0, m, lo};
  endfunction

  function automatic logic [7:0] seg_of(input logic [15:0] v, input logic [31:0] r, input logic rm, input int idx);
    if (rm) return r[idx*8 +: 8];
    return hex_tab[v[idx*4 +: 4]];
  endfunction

  // Call right after the write that enables the display; digit k is driven for SCAN cycles in turn.
  task automatic scan_run(input int n, input int mid_t, input logic [15:0] mid_v);
    int w;
    int idx;
    w = cyc;
    for (int t = 1; t <= n; t++) begin
      idx = ((t - 1) / SCAN) % 4;
      exp_at(w + t, K_AN, {28'h0, ~(4'b0001 << idx)}, "an_scan");
      exp_at(w + t, K_SEGS, {24'h0, seg_of(sseg_m, raw_m, rawmode_m, idx)}, "segs_scan");
      if (t == mid_t) begin
        iobus_addr = A_SSEG; iobus_out = {16'h0, mid_v}; iobus_wr = 1'b1;
      end
      tick();
      if (t == mid_t) begin
        iobus_wr = 1'b0; iobus_addr = 32'h0; sseg_m = mid_v;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    rst_n = 1'b1; iobus_addr = 32'h0; iobus_out = 32'h0; iobus_wr = 1'b0;
    switches = '0; buttons = '0; mcu_reset_req = 1'b0;
    led_m = '0; sseg_m = '0; sw_m = '0; mask_m = '0; edge_m = '0; btn_m = '0; rawmode_m = 1'b0; raw_m = '0;
    #1 rst_n = 1'b0;
    tick();
    pins_reset(cyc);
    pins_reset(cyc + 1);
    tick();
    rd(A_CTRL, 32'h0, "ctrl_in_reset");

    // Release: mcu_reset must stay high for exactly RC edges.
    rst_n = 1'b1;
    r0 = cyc;
    for (int k = 0; k <= RC + 2; k++) begin
      exp_at(r0 + k, K_MRST, (k < RC) ? 32'h1 : 32'h0, "mcu_reset_release");
      exp_at(r0 + k, K_AN, 32'hF, "an_idle");
      exp_at(r0 + k, K_SEGS, 32'hFF, "segs_idle");
      exp_at(r0 + k, K_LEDS, 32'h0, "leds_idle");
    end
    repeat (RC + 3) tick();

    // Two-cycle button glitch must not propagate.
    buttons = 5'b00100; tick(); tick(); buttons = '0;
    for (int k = 0; k < 8; k++) rd(A_BTN, 32'h0, "btn_glitch");
    rd(A_EDGE, 32'h0, "edge_glitch");

    // Clean press: debounced value appears DB+2 cycles after the raw edge.
    buttons = 5'b00100;
    for (int k = 0; k < 8; k++) rd(A_BTN, (k >= DB + 2) ? 32'h4 : 32'h0, "btn_latency");
    btn_m = 5'b00100; edge_m = 5'b00100;
    rd(A_EDGE, 32'h4, "edge_set");
    wr(A_CTRL, ctrl_word(5'b00100, 8'h00)); mask_m = 5'b00100;
    exp_at(cyc, K_IRQ, 32'h0, "irq_lag");
    exp_at(cyc + 1, K_IRQ, 32'h1, "irq_set");
    rd(A_CTRL, ctrl_word(mask_m, 8'h00), "ctrl_mask");
    wr(A_EDGE, 32'h4); edge_m = '0;
    exp_at(cyc, K_IRQ, 32'h1, "irq_hold_after_clr");
    exp_at(cyc + 1, K_IRQ, 32'h0, "irq_clear");
    rd(A_EDGE, 32'h0, "edge_clear");

    // W1C in the same cycle as a fresh edge: set wins.
    buttons = '0; repeat (DB + 6) tick(); btn_m = '0;
    rd(A_BTN, 32'h0, "btn_release");
    buttons = 5'b00100;
    repeat (DB + 1) tick();
    wr(A_EDGE, 32'h4);
    btn_m = 5'b00100; edge_m = 5'b00100;
    rd(A_EDGE, 32'h4, "edge_set_wins");
    wr(A_EDGE, 32'h1F); edge_m = '0;

    // Random switch/button patterns with random IRQ mask.
    mask_m = 5'($urandom);
    wr(A_CTRL, ctrl_word(mask_m, 8'h00));
    rd(A_CTRL, ctrl_word(mask_m, 8'h00), "ctrl_rand_mask");
    for (int it = 0; it < 5; it++) begin
      nsw = 16'($urandom); nbt = 5'($urandom);
      switches = nsw; buttons = nbt;
      repeat (DB + 1) tick();
      rd(A_SW, {16'h0, sw_m}, "sw_hold");
      rd(A_SW, {16'h0, nsw}, "sw_update");
      edge_m = edge_m | (nbt & ~btn_m); btn_m = nbt; sw_m = nsw;
      rd(A_BTN, {27'h0, btn_m}, "btn_rand");
      exp_at(cyc, K_IRQ, {31'h0, |(edge_m & mask_m)}, "irq_rand");
      rd(A_EDGE, {27'h0, edge_m}, "edge_rand");
      wr(A_EDGE, 32'h1F); edge_m = '0;
      tick(); tick();
    end

    // LED register and address decode.
    wr(A_LED, 32'hFFFF_A5A5); led_m = 16'hA5A5;
    exp_at(cyc, K_LEDS, 32'hA5A5, "leds_pin");
    rd(A_LED, 32'h0000_A5A5, "led_read");
    for (int it = 0; it < 3; it++) begin
      rd_tmp = $urandom;
      wr(A_LED, rd_tmp); led_m = rd_tmp[15:0];
      exp_at(cyc, K_LEDS, {16'h0, led_m}, "leds_rand");
      rd(A_LED, {16'h0, led_m}, "led_rand_read");
    end
    wr(BASE + 32'h20, $urandom);
    rd(A_LED, {16'h0, led_m}, "led_after_oob_wr");
    rd(BASE + 32'h20, 32'h0, "oob_read");
    wr(BASE + 32'h1C, $urandom);
    rd(BASE + 32'h1C, 32'h0, "unmapped_read");
    wr(A_LED ^ 32'h0001_0000, {16'h0, ~led_m});
    rd(A_LED, {16'h0, led_m}, "led_after_alias_wr");
    rd(A_LED ^ 32'h0001_0000, 32'h0, "alias_read");

    // Seven-segment scan with a mid-scan value change.
    wr(A_SSEG, 32'hABCD_12EF); sseg_m = 16'h12EF;
    rd(A_SSEG, 32'h0000_12EF, "sseg_read");
    exp_at(cyc, K_AN, 32'hF, "an_disabled");
    wr(A_CTRL, ctrl_word(mask_m, 8'h01));
    exp_at(cyc, K_AN, 32'hF, "an_before_first");
    mv = 16'($urandom);
    scan_run(44, 36, mv);
    wr(A_CTRL, ctrl_word(mask_m, 8'h00));
    for (int k = 1; k <= 10; k++) begin
      exp_at(cyc + k, K_AN, 32'hF, "an_off");
      exp_at(cyc + k, K_SEGS, 32'hFF, "segs_off");
    end
    repeat (10) tick();
    wr(A_CTRL, ctrl_word(mask_m, 8'h01));
    scan_run(12, 0, 16'h0);

`ifdef OTTER_MMIO_SSEG_RAW_EN
    wr(A_RAW, 32'h00FF_7F80); raw_m = 32'h00FF_7F80;
    rd(A_RAW, raw_m, "raw_read");
    wr(A_CTRL, ctrl_word(mask_m, 8'h03)); rawmode_m = 1'b1;
    scan_run(34, 0, 16'h0);
    rd(A_CTRL, ctrl_word(mask_m, 8'h03), "ctrl_raw_read");
    wr(A_CTRL, ctrl_word(mask_m, 8'h00)); rawmode_m = 1'b0;
`else
    wr(A_RAW, 32'h00FF_7F80);
    rd(A_RAW, 32'h0, "raw_absent");
    wr(A_CTRL, ctrl_word(mask_m, 8'h03));
    rd(A_CTRL, ctrl_word(mask_m, 8'h01), "ctrl_raw_ignored");
    wr(A_CTRL, ctrl_word(mask_m, 8'h00));
`endif
    tick();

    // Reset request from RUN: rises 3 edges after the raw edge, falls RC edges after sync req drops.
    q0 = cyc;
    for (int k = 0; k <= RC + 8; k++)
      exp_at(q0 + k, K_MRST, (k >= 3 && k < 5 + RC) ? 32'h1 : 32'h0, "mcu_reset_req_seq");
    mcu_reset_req = 1'b1;
    repeat (3) tick();
    mcu_reset_req = 1'b0;
    rd(A_LED, {16'h0, led_m}, "led_kept_in_hold");
    repeat (RC + 6) tick();

    // rst_n pulse mid-scan with irq and LEDs active.
    buttons = '0; repeat (DB + 4) tick();
    buttons = 5'h1F; repeat (DB + 4) tick();
    wr(A_LED, 32'h0000_3C3C); led_m = 16'h3C3C;
    wr(A_CTRL, ctrl_word(5'h1F, 8'h01)); mask_m = 5'h1F;
    scan_run(10, 0, 16'h0);
    exp_at(cyc, K_IRQ, 32'h1, "irq_before_rst");
    exp_at(cyc, K_LEDS, 32'h3C3C, "leds_before_rst");
    tick();
    rst_n = 1'b0;
    pins_reset(cyc);
    tick();
    pins_reset(cyc);
    rd(A_EDGE, 32'h0, "edge_after_rst");
    rd(A_CTRL, 32'h0, "ctrl_after_rst");
    rd(A_SSEG, 32'h0, "sseg_after_rst");
    rd(A_LED, 32'h0, "led_after_rst");
    rd(A_BTN, 32'h0, "btn_after_rst");
    rst_n = 1'b1;
    repeat (3) tick();

    if (sb.size() != 0) begin
      $display("FAIL unchecked_expectations got=%0d required=0", sb.size());
      n_cmp += sb.size();
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
